rsu_wd_kicker: RTL

RSU_WD_KICKER -- requirements
Module: rsu_wd_kicker

---
 rtl/rsu_wd_pkg.sv | 24 ++
 rtl/rsu_sync2.sv | 21 ++
 rtl/rsu_wd_kicker.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rsu_wd_pkg.sv
// Shared types and reset values for the remote-system-update watchdog kicker.
package rsu_wd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_STARVED,
        ST_RECONF,
        ST_WAIT_CONF,
        ST_FAULT
    } state_t;

    localparam logic        RST_WATCHDOG_RESET   = 1'b0;
    localparam logic        RST_PFL_NRECONFIGURE = 1'b1;
    localparam logic [7:0]  RST_RETRY_COUNT      = 8'd0;
    localparam logic [15:0] RST_KICK_COUNT       = 16'd0;
    localparam logic        RST_FAULT            = 1'b0;

    // True while another reconfiguration attempt is still permitted.
    function automatic logic retry_allowed(input logic [7:0] count, input int unsigned max_retry);
        return 32'(count) < max_retry;
    endfunction

endpackage

// File: rtl/rsu_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module rsu_sync2 (
    input  logic clk,
    input  logic nreset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rsu_wd_kicker.sv
// Watchdog kicker: kicks the external watchdog only while the application
// proves it is alive, and requests bounded reconfiguration when it starves.
module rsu_wd_kicker
    import rsu_wd_pkg::*;
#(
    parameter int unsigned KICK_PERIOD   = 50000000,
    parameter int unsigned NRECONF_PULSE = 16,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        enable,
    input  logic        fpga_conf_done,
    input  logic        app_heartbeat,
    input  logic        watchdog_timed_out,
    output logic        watchdog_reset,
    output logic        pfl_nreconfigure,
    output logic [7:0]  retry_count,
    output logic [15:0] kick_count,
    output logic        fault
);

    localparam int unsigned CNT_W   = $clog2(KICK_PERIOD);
    localparam int unsigned PULSE_W = $clog2(NRECONF_PULSE + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(KICK_PERIOD - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(NRECONF_PULSE - 1);

    logic               conf_done;
    logic               timed_out;
    state_t             state;
    logic [CNT_W-1:0]   period_cnt;
    logic [PULSE_W-1:0] pulse_cnt;
    logic               hb_seen;
    logic               conf_low_seen;

    rsu_sync2 u_sync_conf (
        .clk    (clk),
        .nreset (nreset),
        .d      (fpga_conf_done),
        .q      (conf_done)
    );

    rsu_sync2 u_sync_timeout (
        .clk    (clk),
        .nreset (nreset),
        .d      (watchdog_timed_out),
        .q      (timed_out)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state            <= ST_IDLE;
            watchdog_reset   <= RST_WATCHDOG_RESET;
            pfl_nreconfigure <= RST_PFL_NRECONFIGURE;
            retry_count      <= RST_RETRY_COUNT;
            kick_count       <= RST_KICK_COUNT;
            fault            <= RST_FAULT;
            period_cnt       <= '0;
            pulse_cnt        <= '0;
            hb_seen          <= 1'b0;
            conf_low_seen    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable && conf_done) begin
                        state      <= ST_ARMED;
                        period_cnt <= '0;
                        hb_seen    <= 1'b0;
                    end
                end

                ST_ARMED, ST_STARVED: begin
                    // A watchdog timeout outranks both a kick and a disable.
                    if (timed_out) begin
                        if (retry_allowed(retry_count, MAX_RETRY)) begin
                            state            <= ST_RECONF;
                            retry_count      <= retry_count + 8'd1;
                            pfl_nreconfigure <= 1'b0;
                            pulse_cnt        <= '0;
                        end else begin
                            state <= ST_FAULT;
                            fault <= 1'b1;
                        end
                    end else if (!enable || !conf_done) begin
                        state <= ST_IDLE;
                    end else if (state == ST_ARMED) begin
                        if (period_cnt == CNT_LAST) begin
                            if (hb_seen || app_heartbeat) begin
                                watchdog_reset <= ~watchdog_reset;
                                kick_count     <= kick_count + 16'd1;
                                retry_count    <= '0;
                                hb_seen        <= 1'b0;
                                period_cnt     <= '0;
                            end else begin
                                state <= ST_STARVED;
                            end
                        end else begin
                            period_cnt <= period_cnt + CNT_W'(1);
                            if (app_heartbeat) begin
                                hb_seen <= 1'b1;
                            end
                        end
                    end
                end

                ST_RECONF: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        state            <= ST_WAIT_CONF;
                        pfl_nreconfigure <= 1'b1;
                        conf_low_seen    <= 1'b0;
                    end else begin
                        pulse_cnt <= pulse_cnt + PULSE_W'(1);
                    end
                end

                // The new image must first drop conf_done, then raise it again.
                ST_WAIT_CONF: begin
                    if (!conf_done) begin
                        conf_low_seen <= 1'b1;
                    end else if (conf_low_seen) begin
                        state <= ST_IDLE;
                    end
                end

                ST_FAULT: begin
                    fault            <= 1'b1;
                    pfl_nreconfigure <= 1'b1;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
